// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
//  mem_access_unit_if : CPU request/response and memory strobe bundle
//  Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_unit_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    // Environment side: issues CPU requests and returns memory read data.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_signed, mem_rdata,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_err,
        input  mem_addr, mem_wdata, mem_size, mem_we, mem_re
    );

    // Unit side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_signed, mem_rdata,
        output cpu_ready, cpu_done, cpu_rdata, cpu_err,
        output mem_addr, mem_wdata, mem_size, mem_we, mem_re
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
//  mem_access_unit : load/store unit with lane extraction and byte splitting
//  Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] SPLIT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  r_state;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic [1:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_size;
    logic        r_mem_we;
    logic        r_mem_re;

    logic        w_aligned;
    logic        w_illegal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic        w_split_last;
    logic [1:0]  w_cnt_next;
    logic [7:0]  w_wbyte_next;
    logic [31:0] w_asm;
    logic [31:0] w_asm_ext;

    assign w_aligned = (bus.cpu_size == 2'd0) ||
                       ((bus.cpu_size == 2'd1) && !bus.cpu_addr[0]) ||
                       ((bus.cpu_size == 2'd3) && (bus.cpu_addr[1:0] == 2'b00));
    assign w_illegal = (bus.cpu_size == 2'd2) || (!w_aligned && !SPLIT_EN);

    // Lane selection follows the address currently on the memory bus,
    // which equals the request address in ACCESS and addr+i in SPLIT.
    always_comb begin
        w_byte = 8'd0;
        case (r_mem_addr[1:0])
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
    end

    assign w_half = r_mem_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_load_val = bus.mem_rdata;
        case (r_size)
            2'd0:    w_load_val = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            2'd1:    w_load_val = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_load_val = bus.mem_rdata;
        endcase
    end

    assign w_split_last = (r_size == 2'd3) ? (r_cnt == 2'd3) : (r_cnt == 2'd1);
    assign w_cnt_next   = r_cnt + 2'd1;

    always_comb begin
        w_wbyte_next = 8'd0;
        case (w_cnt_next)
            2'd0:    w_wbyte_next = r_wdata[7:0];
            2'd1:    w_wbyte_next = r_wdata[15:8];
            2'd2:    w_wbyte_next = r_wdata[23:16];
            default: w_wbyte_next = r_wdata[31:24];
        endcase
    end

    // r_rdata is cleared at accept, so each split byte can simply be OR-ed in.
    assign w_asm     = r_rdata | ({24'd0, w_byte} << {r_cnt, 3'b000});
    assign w_asm_ext = (w_split_last && (r_size == 2'd1) && r_signed) ?
                       {{16{w_asm[15]}}, w_asm[15:0]} : w_asm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'd0;
            r_wdata     <= 32'd0;
            r_cnt       <= 2'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_size  <= 2'd0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        r_we     <= bus.cpu_we;
                        r_signed <= bus.cpu_signed;
                        r_size   <= bus.cpu_size;
                        r_wdata  <= bus.cpu_wdata;
                        r_cnt    <= 2'd0;
                        r_rdata  <= 32'd0;
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_err      <= 1'b0;
                            r_mem_addr <= bus.cpu_addr;
                            r_mem_we   <= bus.cpu_we;
                            r_mem_re   <= !bus.cpu_we;
                            if (w_aligned) begin
                                r_state     <= ACCESS;
                                r_mem_size  <= bus.cpu_size;
                                r_mem_wdata <= bus.cpu_wdata;
                            end else begin
                                r_state     <= SPLIT;
                                r_mem_size  <= 2'd0;
                                r_mem_wdata <= {24'd0, bus.cpu_wdata[7:0]};
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load_val;
                    end
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_state  <= DONE;
                end
                SPLIT: begin
                    if (!r_we) begin
                        r_rdata <= w_asm_ext;
                    end
                    if (w_split_last) begin
                        r_mem_we <= 1'b0;
                        r_mem_re <= 1'b0;
                        r_state  <= DONE;
                    end else begin
                        r_cnt       <= w_cnt_next;
                        r_mem_addr  <= r_mem_addr + 32'd1;
                        r_mem_wdata <= {24'd0, w_wbyte_next};
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = (r_state == IDLE);
    assign bus.cpu_done  = (r_state == DONE);
    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_err   = r_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_size  = r_mem_size;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
//  tb_mem_access_unit : directed self-checking bench for mem_access_unit
//  Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic        sgn   = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [1:0]  size  = 2'd0;
    int          sel   = 0;

    int n_cmp    = 0;
    int n_fail   = 0;
    int n_strb1  = 0;

    logic [31:0] mem0 [0:1023];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        q_we   [$];
    logic [1:0]  q_size [$];

    mem_access_unit_if b0 ();
    mem_access_unit_if b1 ();

    mem_access_unit #(.SPLIT_EN(1'b1)) dut0 (.clock(clock), .reset(reset), .bus(b0));
    mem_access_unit #(.SPLIT_EN(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(b1));

    always #5 clock = ~clock;

    assign b0.cpu_req    = req && (sel == 0);
    assign b0.cpu_we     = we;
    assign b0.cpu_addr   = addr;
    assign b0.cpu_wdata  = wdata;
    assign b0.cpu_size   = size;
    assign b0.cpu_signed = sgn;
    assign b0.mem_rdata  = mem0[b0.mem_addr[11:2]];

    assign b1.cpu_req    = req && (sel == 1);
    assign b1.cpu_we     = we;
    assign b1.cpu_addr   = addr;
    assign b1.cpu_wdata  = wdata;
    assign b1.cpu_size   = size;
    assign b1.cpu_signed = sgn;
    assign b1.mem_rdata  = 32'hCAFEF00D;

    logic        done_s, ready_s, err_s;
    logic [31:0] rdata_s;
    assign done_s  = (sel == 0) ? b0.cpu_done  : b1.cpu_done;
    assign ready_s = (sel == 0) ? b0.cpu_ready : b1.cpu_ready;
    assign err_s   = (sel == 0) ? b0.cpu_err   : b1.cpu_err;
    assign rdata_s = (sel == 0) ? b0.cpu_rdata : b1.cpu_rdata;

    // Byte-lane memory model for instance 0
    always @(posedge clock) begin
        if (b0.mem_we) begin
            case (b0.mem_size)
                2'd0:    mem0[b0.mem_addr[11:2]][{b0.mem_addr[1:0], 3'b000} +: 8] <= b0.mem_wdata[7:0];
                2'd1:    mem0[b0.mem_addr[11:2]][{b0.mem_addr[1], 4'b0000} +: 16] <= b0.mem_wdata[15:0];
                default: mem0[b0.mem_addr[11:2]] <= b0.mem_wdata;
            endcase
        end
        if (b0.mem_we || b0.mem_re) begin
            q_addr.push_back(b0.mem_addr);
            q_data.push_back(b0.mem_wdata);
            q_we.push_back(b0.mem_we);
            q_size.push_back(b0.mem_size);
        end
        if (b1.mem_we || b1.mem_re) begin
            n_strb1 <= n_strb1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_we.delete();
        q_size.delete();
    endtask

    // One request: accept on the next posedge, scramble inputs, then wait for done.
    task automatic run_op(input int s, input logic op_we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          input logic hold, output int lat, output logic [31:0] rd,
                          output logic er);
        logic got;
        @(negedge clock);
        clear_log();
        sel = s; req = 1'b1; we = op_we; addr = a; wdata = wd; size = sz; sgn = sg;
        @(posedge clock);
        #1;
        if (!hold) req = 1'b0;
        we = ~op_we; addr = ~a; wdata = ~wd; sgn = ~sg;
        size = (sz == 2'd3) ? 2'd0 : 2'd3;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clock);
            lat++;
            if (done_s) got = 1'b1;
        end
        if (hold) begin
            chk("ready_low_in_done", {31'd0, ready_s}, 32'd0);
            req = 1'b0;
        end
        if (!got) lat = -1;
        rd = rdata_s;
        er = err_s;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;

        // Asynchronous reset, observed before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst_ready", {31'd0, b0.cpu_ready}, 32'd1);
        chk("rst_done",  {31'd0, b0.cpu_done},  32'd0);
        chk("rst_err",   {31'd0, b0.cpu_err},   32'd0);
        chk("rst_rdata", b0.cpu_rdata, 32'd0);
        chk("rst_strb",  {30'd0, b0.mem_we, b0.mem_re}, 32'd0);
        chk("rst_maddr", b0.mem_addr,  32'd0);
        chk("rst_mwd",   b0.mem_wdata, 32'd0);
        chk("rst_msize", {30'd0, b0.mem_size}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Aligned word store, then load
        run_op(0, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 2'd3, 1'b0, 1'b0, lat, rd, er);
        chk("st_w_lat",   lat, 32'd2);
        chk("st_w_rdata", rd, 32'd0);
        chk("st_w_n",     q_addr.size(), 32'd1);
        chk("st_w_we",    {31'd0, q_we[0]}, 32'd1);
        chk("st_w_size",  {30'd0, q_size[0]}, 32'd3);
        chk("st_w_mem",   mem0[2], 32'hDEAD_BEEF);

        run_op(0, 1'b0, 32'h1000_0008, 32'h0, 2'd3, 1'b1, 1'b0, lat, rd, er);
        chk("ld_w_lat",   lat, 32'd2);
        chk("ld_w_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_w_n",     q_addr.size(), 32'd1);
        chk("ld_w_we",    {31'd0, q_we[0]}, 32'd0);

        // Byte and half extraction
        run_op(0, 1'b0, 32'h1000_0009, 32'h0, 2'd0, 1'b1, 1'b0, lat, rd, er);
        chk("ld_b_s", rd, 32'hFFFF_FFBE);
        run_op(0, 1'b0, 32'h1000_0009, 32'h0, 2'd0, 1'b0, 1'b0, lat, rd, er);
        chk("ld_b_u", rd, 32'h0000_00BE);
        run_op(0, 1'b0, 32'h1000_000A, 32'h0, 2'd1, 1'b1, 1'b0, lat, rd, er);
        chk("ld_h_s", rd, 32'hFFFF_DEAD);
        run_op(0, 1'b0, 32'h1000_0008, 32'h0, 2'd1, 1'b0, 1'b0, lat, rd, er);
        chk("ld_h_u", rd, 32'h0000_BEEF);

        // Misaligned word store split into four byte writes
        run_op(0, 1'b1, 32'h1000_0003, 32'h1122_3344, 2'd3, 1'b0, 1'b0, lat, rd, er);
        chk("st_mw_lat", lat, 32'd5);
        chk("st_mw_n",   q_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_addr.size()) begin
                chk("st_mw_addr", q_addr[i], 32'h1000_0003 + 32'(i));
                chk("st_mw_size", {30'd0, q_size[i]}, 32'd0);
            end
        end
        if (q_data.size() == 4) begin
            chk("st_mw_d0", q_data[0], 32'h44);
            chk("st_mw_d1", q_data[1], 32'h33);
            chk("st_mw_d2", q_data[2], 32'h22);
            chk("st_mw_d3", q_data[3], 32'h11);
        end
        chk("st_mw_mem0", {24'd0, mem0[0][31:24]}, 32'h44);
        chk("st_mw_mem1", {8'd0, mem0[1][23:0]}, 32'h0011_2233);

        run_op(0, 1'b0, 32'h1000_0003, 32'h0, 2'd3, 1'b0, 1'b0, lat, rd, er);
        chk("ld_mw_lat",   lat, 32'd5);
        chk("ld_mw_rdata", rd, 32'h1122_3344);

        // Misaligned signed half: sign comes from bit 15 of the assembled value
        run_op(0, 1'b0, 32'h1000_0009, 32'h0, 2'd1, 1'b1, 1'b0, lat, rd, er);
        chk("ld_mh_lat",   lat, 32'd3);
        chk("ld_mh_rdata", rd, 32'hFFFF_ADBE);

        // Illegal size
        run_op(0, 1'b0, 32'h1000_0008, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er);
        chk("ill_lat",   lat, 32'd1);
        chk("ill_err",   {31'd0, er}, 32'd1);
        chk("ill_rdata", rd, 32'd0);
        chk("ill_strb",  q_addr.size(), 32'd0);

        // SPLIT_EN=0 instance
        run_op(1, 1'b0, 32'h0000_0020, 32'h0, 2'd3, 1'b0, 1'b0, lat, rd, er);
        chk("ns_w_lat",   lat, 32'd2);
        chk("ns_w_rdata", rd, 32'hCAFE_F00D);
        chk("ns_w_err",   {31'd0, er}, 32'd0);
        run_op(1, 1'b0, 32'h1000_0001, 32'h0, 2'd1, 1'b0, 1'b0, lat, rd, er);
        chk("ns_h_lat",   lat, 32'd1);
        chk("ns_h_err",   {31'd0, er}, 32'd1);
        chk("ns_h_rdata", rd, 32'd0);
        chk("ns_strb",    n_strb1, 32'd1);

        // Address wrap across 0xFFFFFFFF
        run_op(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_00A5, 2'd0, 1'b0, 1'b0, lat, rd, er);
        run_op(0, 1'b1, 32'h0000_0000, 32'h0000_0080, 2'd0, 1'b0, 1'b0, lat, rd, er);
        run_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 2'd1, 1'b1, 1'b0, lat, rd, er);
        chk("wrap_lat",   lat, 32'd3);
        chk("wrap_n",     q_addr.size(), 32'd2);
        if (q_addr.size() == 2) begin
            chk("wrap_a0", q_addr[0], 32'hFFFF_FFFF);
            chk("wrap_a1", q_addr[1], 32'h0000_0000);
        end
        chk("wrap_rdata", rd, 32'hFFFF_80A5);

        // Request held high while busy is not queued
        run_op(0, 1'b0, 32'h1000_0008, 32'h0, 2'd3, 1'b0, 1'b1, lat, rd, er);
        chk("hold_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("hold_ready", {31'd0, b0.cpu_ready}, 32'd1);
        chk("hold_n",     q_addr.size(), 32'd1);

        // Reset in the middle of a split word store
        run_op(0, 1'b1, 32'h1000_0010, 32'hAABB_CCDD, 2'd3, 1'b0, 1'b0, lat, rd, er);
        run_op(0, 1'b1, 32'h1000_0014, 32'h5566_7788, 2'd3, 1'b0, 1'b0, lat, rd, er);
        @(negedge clock);
        sel = 0; req = 1'b1; we = 1'b1; addr = 32'h1000_0011; wdata = 32'h1122_3344;
        size = 2'd3; sgn = 1'b0;
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rs_pre_addr", b0.mem_addr, 32'h1000_0013);
        #1 reset = 1'b1;
        #1;
        chk("rs_strb",  {30'd0, b0.mem_we, b0.mem_re}, 32'd0);
        chk("rs_ready", {31'd0, b0.cpu_ready}, 32'd1);
        chk("rs_done",  {31'd0, b0.cpu_done}, 32'd0);
        chk("rs_maddr", b0.mem_addr, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rs_done2", {31'd0, b0.cpu_done}, 32'd0);
        chk("rs_mem4",  mem0[4], 32'hAA33_44DD);
        chk("rs_mem5",  mem0[5], 32'h5566_7788);

        // First request after reset is accepted normally
        run_op(0, 1'b0, 32'h1000_0010, 32'h0, 2'd3, 1'b0, 1'b0, lat, rd, er);
        chk("post_lat",   lat, 32'd2);
        chk("post_rdata", rd, 32'hAA33_44DD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
